// File: rtl/uart_rx_path.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with a one-cycle valid strobe.
// Define UART_RX_PARITY_EN for 8E1 frames and the uart_rx_parity_err_o output.
module uart_rx_path #(
    parameter logic [12:0] BAUD_DIV     = 13'd5208,
    parameter logic [12:0] BAUD_DIV_CAP = 13'd2604
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       uart_rx_i,
    output logic [7:0] uart_rx_data_o,
    output logic       uart_rx_valid_o,
    output logic       uart_rx_frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       uart_rx_parity_err_o,
`endif
    output logic       uart_rx_busy_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic        sync_q1;
    logic        sync_q2;
    logic        hist_q;
    logic        fall;
    logic [2:0]  state_q;
    logic [12:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q;
`endif

    // Synchroniser and history reset to the idle level so release never looks like a start edge.
    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync_q1 <= uart_rx_i;
            sync_q2 <= sync_q1;
            hist_q  <= sync_q2;
        end
    end

    assign fall           = hist_q & ~sync_q2;
    assign uart_rx_busy_o = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q             <= S_IDLE;
            cnt_q               <= '0;
            bit_idx_q           <= '0;
            shreg_q             <= '0;
            uart_rx_data_o      <= '0;
            uart_rx_valid_o     <= 1'b0;
            uart_rx_frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q            <= 1'b0;
            uart_rx_parity_err_o <= 1'b0;
`endif
        end else begin
            uart_rx_valid_o     <= 1'b0;
            uart_rx_frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            uart_rx_parity_err_o <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (fall) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == BAUD_DIV_CAP - 13'd1) begin
                        cnt_q <= '0;
                        // A line already back high at mid-start was a glitch.
                        if (!sync_q2) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BAUD_DIV - 13'd1) begin
                        cnt_q              <= '0;
                        shreg_q[bit_idx_q] <= sync_q2;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == BAUD_DIV - 13'd1) begin
                        cnt_q     <= '0;
                        par_bad_q <= ^{shreg_q, sync_q2};
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == BAUD_DIV - 13'd1) begin
                        cnt_q <= '0;
                        if (sync_q2) begin
                            state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                uart_rx_parity_err_o <= 1'b1;
                            end else begin
                                uart_rx_data_o  <= shreg_q;
                                uart_rx_valid_o <= 1'b1;
                            end
`else
                            uart_rx_data_o  <= shreg_q;
                            uart_rx_valid_o <= 1'b1;
`endif
                        end else begin
                            uart_rx_frame_err_o <= 1'b1;
                            state_q             <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                S_BREAK: begin
                    // Wait out a held-low line so it cannot retrigger a start.
                    cnt_q <= '0;
                    if (sync_q2) state_q <= S_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_path.sv
// Scoreboard bench for uart_rx_path with BAUD_DIV=16, BAUD_DIV_CAP=8.
`timescale 1ns/1ps
module tb_uart_rx_path;

    localparam logic [12:0] DIV = 13'd16;
    localparam logic [12:0] CAP = 13'd8;
    localparam int          BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       busy;

    uart_rx_path #(
        .BAUD_DIV     (DIV),
        .BAUD_DIV_CAP (CAP)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .uart_rx_i           (rx),
        .uart_rx_data_o      (data),
        .uart_rx_valid_o     (valid),
        .uart_rx_frame_err_o (ferr),
`ifdef UART_RX_PARITY_EN
        .uart_rx_parity_err_o(perr),
`endif
        .uart_rx_busy_o      (busy)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         valid_cyc[$];
    int         valid_seen, ferr_seen, perr_seen, busy_seen;
    logic [7:0] last_good = 8'h00;

    task automatic clear_counts();
        valid_seen = 0;
        ferr_seen  = 0;
        perr_seen  = 0;
        busy_seen  = 0;
        valid_cyc.delete();
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit,
                              input logic stop_bit, input bit push);
        if (push) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    // Bounded monitor: pops the scoreboard on every valid strobe.
    task automatic watch(input int cycles);
        logic [7:0] e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (ferr) ferr_seen++;
            if (perr) perr_seen++;
            if (valid) begin
                valid_seen++;
                valid_cyc.push_back(i);
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_valid: data_o=%02h with no byte expected", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        tests_failed++;
                        $display("FAIL rx_data: got %02h expected %02h", data, e);
                    end
                    last_good = e;
                end
                tests_run++;
                if (ferr !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL valid_with_ferr: frame_err_o=%b expected 0", ferr);
                end
            end
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({data, valid, ferr, perr, busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: data=%02h valid=%b ferr=%b perr=%b busy=%b expected all 0",
                     data, valid, ferr, perr, busy);
        end
        rst_n = 1'b1;
        clear_counts();
        watch(20);
        expect_int("reset_idle_pulses", valid_seen + ferr_seen + perr_seen + busy_seen, 0);
    endtask

    task automatic test_single_byte();
        clear_counts();
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1);
            watch(200);
        join
        expect_int("single_valid_count", valid_seen, 1);
        expect_int("single_ferr_count", ferr_seen, 0);
        expect_int("single_queue_left", exp_q.size(), 0);
        expect_int("single_busy_after", int'(busy), 0);
        expect_int("single_data_hold", int'(data), 8'hA5);
    endtask

    task automatic test_reset_mid_frame();
        rx = 1'b0;
        repeat (40) @(negedge clk);
        expect_int("midframe_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({data, valid, ferr, perr, busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL midframe_reset_outputs: data=%02h valid=%b ferr=%b perr=%b busy=%b expected all 0",
                     data, valid, ferr, perr, busy);
        end
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        clear_counts();
        watch(250);
        expect_int("post_reset_pulses", valid_seen + ferr_seen + perr_seen, 0);
        expect_int("post_reset_busy", busy_seen, 0);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        fork
            begin
                send_frame(8'h00, ^8'h00, 1'b1, 1'b1);
                send_frame(8'hFF, ^8'hFF, 1'b1, 1'b1);
            end
            watch(400);
        join
        expect_int("b2b_valid_count", valid_seen, 2);
        if (valid_cyc.size() == 2)
            expect_int("b2b_spacing", valid_cyc[1] - valid_cyc[0], PAR_EN ? 176 : 160);
        expect_int("b2b_ferr_count", ferr_seen, 0);
        expect_int("b2b_data_last", int'(data), 8'hFF);
    endtask

    task automatic test_glitch();
        clear_counts();
        fork
            begin
                rx = 1'b0;
                repeat (4) @(negedge clk);
                rx = 1'b1;
            end
            watch(40);
        join
        tests_run++;
        if (busy_seen == 0) begin
            tests_failed++;
            $display("FAIL glitch_busy_pulse: busy cycles %0d expected >0", busy_seen);
        end
        expect_int("glitch_busy_after", int'(busy), 0);
        expect_int("glitch_valid", valid_seen, 0);
        expect_int("glitch_ferr", ferr_seen, 0);
    endtask

    task automatic test_frame_error();
        logic [7:0] held;
        held = last_good;
        clear_counts();
        fork
            begin
                send_frame(8'h5A, ^8'h5A, 1'b0, 1'b0);
                rx = 1'b0;
                repeat (34) @(negedge clk);
                expect_int("ferr_busy_held", int'(busy), 1);
                rx = 1'b1;
            end
            watch(260);
        join
        expect_int("ferr_count", ferr_seen, 1);
        expect_int("ferr_valid", valid_seen, 0);
        expect_int("ferr_data_unchanged", int'(data), int'(held));
        expect_int("ferr_busy_after", int'(busy), 0);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_counts();
        fork
            send_frame(8'h03, 1'b1, 1'b1, 1'b0);
            watch(200);
        join
        expect_int("parity_bad_perr", perr_seen, 1);
        expect_int("parity_bad_valid", valid_seen, 0);
        expect_int("parity_bad_ferr", ferr_seen, 0);
        expect_int("parity_bad_data", int'(data), int'(last_good));
        clear_counts();
        fork
            send_frame(8'h03, 1'b0, 1'b1, 1'b1);
            watch(200);
        join
        expect_int("parity_good_valid", valid_seen, 1);
        expect_int("parity_good_perr", perr_seen, 0);
        expect_int("parity_good_data", int'(data), 8'h03);
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_reset_mid_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
